// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow pulses and synchronous flush. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_thresh #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       w_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       r_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // A full FIFO still takes a write when a read frees the slot on the same edge.
    assign rd_ok = r_en & ~empty;
    assign wr_ok = w_en & (~full | rd_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= w_en & ~wr_ok;
            underflow <= r_en & ~rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && !clr && wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_ptr];
`else
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (clr) begin
            dout_q <= '0;
        end else if (rd_ok) begin
            dout_q <= mem[rd_ptr];
        end
    end

    assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Scoreboard testbench for sync_fifo_thresh: a queue-based reference model predicts
// the post-edge state of every cycle and a negedge monitor compares it against the DUT.
module tb_sync_fifo_thresh;

    localparam int DEPTH    = 8;
    localparam int WIDTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int AE_LEVEL = 2;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             w_en;
    logic [WIDTH-1:0] data_in;
    logic             r_en;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    typedef struct {
        int cnt;
        int full;
        int empty;
        int af;
        int ae;
        int ov;
        int un;
        int dout;
    } exp_t;

    exp_t sb[$];
    int   model_q[$];
    int   model_dout;
    int   checks;
    int   errors;

    sync_fifo_thresh #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .w_en(w_en),
        .data_in(data_in),
        .r_en(r_en),
        .data_out(data_out),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of requests and queue the state the FIFO must show after the edge.
    task automatic applyStimulus(input bit w, input int d, input bit r, input bit c);
        exp_t e;
        bit   was_empty;
        bit   was_full;
        bit   rd_acc;
        bit   wr_acc;
        int   ov;
        int   un;
        int   popped;
        @(negedge clk);
        #1;
        w_en    = w;
        data_in = d[WIDTH-1:0];
        r_en    = r;
        clr     = c;
        was_empty = (model_q.size() == 0);
        was_full  = (model_q.size() == DEPTH);
        ov = 0;
        un = 0;
        if (c) begin
            model_q.delete();
            model_dout = 0;
        end else begin
            rd_acc = r && !was_empty;
            wr_acc = w && (!was_full || rd_acc);
            ov = (w && !wr_acc) ? 1 : 0;
            un = (r && !rd_acc) ? 1 : 0;
            if (rd_acc) begin
                popped = model_q.pop_front();
                model_dout = popped;
            end
            if (wr_acc) begin
                model_q.push_back(d & 8'hFF);
            end
        end
`ifdef SYNC_FIFO_FWFT_EN
        model_dout = (model_q.size() == 0) ? 0 : model_q[0];
`endif
        e.cnt   = model_q.size();
        e.full  = (model_q.size() == DEPTH) ? 1 : 0;
        e.empty = (model_q.size() == 0) ? 1 : 0;
        e.af    = (model_q.size() >= AF_LEVEL) ? 1 : 0;
        e.ae    = (model_q.size() <= AE_LEVEL) ? 1 : 0;
        e.ov    = ov;
        e.un    = un;
        e.dout  = model_dout;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("count", int'(count), e.cnt);
            checkOutput("full", int'(full), e.full);
            checkOutput("empty", int'(empty), e.empty);
            checkOutput("almost_full", int'(almost_full), e.af);
            checkOutput("almost_empty", int'(almost_empty), e.ae);
            checkOutput("overflow", int'(overflow), e.ov);
            checkOutput("underflow", int'(underflow), e.un);
            checkOutput("data_out", int'(data_out), e.dout);
        end
    end

    task automatic idleInputs();
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        clr  = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_count"}, int'(count), 0);
        checkOutput({tag, "_empty"}, int'(empty), 1);
        checkOutput({tag, "_almost_empty"}, int'(almost_empty), 1);
        checkOutput({tag, "_full"}, int'(full), 0);
        checkOutput({tag, "_almost_full"}, int'(almost_full), 0);
        checkOutput({tag, "_overflow"}, int'(overflow), 0);
        checkOutput({tag, "_underflow"}, int'(underflow), 0);
        checkOutput({tag, "_data_out"}, int'(data_out), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        model_dout = 0;
        rst_n   = 1'b0;
        clr     = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        #12;
        checkResetState("reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Fill then drain in order.
        for (int i = 1; i <= 8; i++) applyStimulus(1, i, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0);

        // Overflow on a full FIFO.
        for (int i = 1; i <= 8; i++) applyStimulus(1, i, 0, 0);
        applyStimulus(1, 8'hAA, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0);

        // Underflow on empty, then simultaneous read/write while empty.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 8'h3C, 1, 0);
        applyStimulus(0, 0, 1, 0);

        // Full FIFO with simultaneous read/write, then drain through the wrap.
        for (int i = 1; i <= 8; i++) applyStimulus(1, i, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 8'h55, 1, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0);

        // Flush beats a concurrent write.
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'h90 + i, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 8'hEE, 1, 1);
        applyStimulus(1, 8'h77, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);

        // Head-word presentation sequence.
        applyStimulus(1, 8'h11, 0, 0);
        applyStimulus(1, 8'h22, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'hC0 + i, 0, 0);
        applyStimulus(1, 8'hC4, 1, 0);
        idleInputs();
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("async_reset");
        model_q.delete();
        model_dout = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 8'h5A, 0, 0);
        applyStimulus(0, 0, 1, 0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 55, int'($urandom_range(0, 255)),
                          $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
        end
        applyStimulus(0, 0, 0, 0);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
